// File: rtl/dmem_arbiter.sv
// Two-port (CPU + debug/loader) arbiter in front of a single-port synchronous data memory.
// Grants are combinational in the request cycle. Every grant gets exactly one response
// on the granted port in the next cycle. Contended cycles are counted in a saturating counter.
module dmem_arbiter #(
    parameter int ADDR_WIDTH = 11,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    // CPU port
    input  logic                  cpu_req,
    input  logic                  cpu_we,
    input  logic [31:0]           cpu_addr,
    input  logic [31:0]           cpu_wdata,
    input  logic [3:0]            cpu_be,
    output logic                  cpu_gnt,
    output logic                  cpu_stall,
    output logic                  cpu_rvalid,
    output logic                  cpu_err,
    output logic [31:0]           cpu_rdata,
    // debug / loader port
    input  logic                  dbg_req,
    input  logic                  dbg_we,
    input  logic [31:0]           dbg_addr,
    input  logic [31:0]           dbg_wdata,
    input  logic [3:0]            dbg_be,
    output logic                  dbg_gnt,
    output logic                  dbg_rvalid,
    output logic                  dbg_err,
    output logic [31:0]           dbg_rdata,
    // memory side
    output logic                  mem_en,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [31:0]           mem_wdata,
    output logic [3:0]            mem_be,
    input  logic [31:0]           mem_rdata,
    // statistics
    output logic [CNT_WIDTH-1:0]  conflict_cnt
);

    typedef enum logic { IDLE = 1'b0, RESP = 1'b1 } state_t;
    typedef enum logic { PORT_CPU = 1'b0, PORT_DBG = 1'b1 } port_t;

    state_t               state;
    port_t                last_grant;
    port_t                rsp_port;   // port owed the pending response
    logic                 rsp_err;    // pending response is for an illegal access
    logic                 rsp_rd;     // pending response is for a read
    logic [CNT_WIDTH-1:0] cnt_q;

    logic        any_gnt;
    logic        sel_we;
    logic [31:0] sel_addr;
    logic [31:0] sel_wdata;
    logic [3:0]  sel_be;
    logic        legal;
    logic        rsp_live;
    logic [31:0] rsp_data;

    // Arbitration: a lone requester wins at once; on contention the port that did not
    // win last time goes first, so a loser waits at most one cycle.
    always_comb begin
        cpu_gnt = ~reset & cpu_req & (~dbg_req | (last_grant == PORT_DBG));
        dbg_gnt = ~reset & dbg_req & ~cpu_gnt;
        any_gnt = cpu_gnt | dbg_gnt;
    end

    assign cpu_stall = ~reset & cpu_req & ~cpu_gnt;

    // Winner mux and legality check: word aligned and inside the memory window.
    always_comb begin
        sel_we    = dbg_gnt ? dbg_we    : cpu_we;
        sel_addr  = dbg_gnt ? dbg_addr  : cpu_addr;
        sel_wdata = dbg_gnt ? dbg_wdata : cpu_wdata;
        sel_be    = dbg_gnt ? dbg_be    : cpu_be;
        legal     = (sel_addr[1:0] == 2'b00) && ((sel_addr >> (ADDR_WIDTH + 2)) == 32'd0);
    end

    // Memory strobes; illegal grants never reach memory and idle buses are held at zero.
    always_comb begin
        mem_en    = any_gnt & legal;
        mem_we    = mem_en & sel_we;
        mem_addr  = mem_en ? sel_addr[ADDR_WIDTH+1:2] : '0;
        mem_wdata = mem_en ? sel_wdata : 32'd0;
        mem_be    = mem_en ? sel_be : 4'd0;
    end

    // Response pipeline: record who was granted and what kind of access it was,
    // so a grant in the response cycle cannot disturb the response being returned.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            last_grant <= PORT_DBG;
            rsp_port   <= PORT_CPU;
            rsp_err    <= 1'b0;
            rsp_rd     <= 1'b0;
        end else if (any_gnt) begin
            state      <= RESP;
            last_grant <= dbg_gnt ? PORT_DBG : PORT_CPU;
            rsp_port   <= dbg_gnt ? PORT_DBG : PORT_CPU;
            rsp_err    <= ~legal;
            rsp_rd     <= ~sel_we;
        end else begin
            state      <= IDLE;
        end
    end

    // Saturating count of cycles in which both ports requested.
    always_ff @(posedge clk) begin
        if (reset)
            cnt_q <= '0;
        else if (cpu_req && dbg_req && (cnt_q != {CNT_WIDTH{1'b1}}))
            cnt_q <= cnt_q + 1'b1;
    end

    assign conflict_cnt = reset ? '0 : cnt_q;

    // Response steering; reset masks any response that was pending when it arrived.
    always_comb begin
        rsp_live   = (state == RESP) & ~reset;
        rsp_data   = (rsp_rd & ~rsp_err) ? mem_rdata : 32'd0;
        cpu_rvalid = rsp_live & (rsp_port == PORT_CPU);
        dbg_rvalid = rsp_live & (rsp_port == PORT_DBG);
        cpu_err    = cpu_rvalid & rsp_err;
        dbg_err    = dbg_rvalid & rsp_err;
        cpu_rdata  = cpu_rvalid ? rsp_data : 32'd0;
        dbg_rdata  = dbg_rvalid ? rsp_data : 32'd0;
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: reset, single-port store/load, contention,
// illegal accesses, reset during a pending response and counter saturation.
module tb_dmem_arbiter;

    localparam int AW = 11;
    localparam int CW = 4;

    logic          clk;
    logic          reset;
    logic          cpu_req, cpu_we, cpu_gnt, cpu_stall, cpu_rvalid, cpu_err;
    logic [31:0]   cpu_addr, cpu_wdata, cpu_rdata;
    logic [3:0]    cpu_be;
    logic          dbg_req, dbg_we, dbg_gnt, dbg_rvalid, dbg_err;
    logic [31:0]   dbg_addr, dbg_wdata, dbg_rdata;
    logic [3:0]    dbg_be;
    logic          mem_en, mem_we;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata, mem_rdata;
    logic [3:0]    mem_be;
    logic [CW-1:0] conflict_cnt;

    int errors = 0;
    int checks = 0;

    logic [31:0] mem_arr [0:(1<<AW)-1];

    dmem_arbiter #(.ADDR_WIDTH(AW), .CNT_WIDTH(CW)) u_dut (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_be(cpu_be), .cpu_gnt(cpu_gnt), .cpu_stall(cpu_stall), .cpu_rvalid(cpu_rvalid),
        .cpu_err(cpu_err), .cpu_rdata(cpu_rdata),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
        .dbg_be(dbg_be), .dbg_gnt(dbg_gnt), .dbg_rvalid(dbg_rvalid), .dbg_err(dbg_err),
        .dbg_rdata(dbg_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_be(mem_be), .mem_rdata(mem_rdata),
        .conflict_cnt(conflict_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous-read memory with byte-enabled writes.
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) begin
                for (int b = 0; b < 4; b++)
                    if (mem_be[b]) mem_arr[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
            end else begin
                mem_rdata <= mem_arr[mem_addr];
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0; cpu_be = 0;
        dbg_req = 0; dbg_we = 0; dbg_addr = 0; dbg_wdata = 0; dbg_be = 0;
    endtask

    initial begin
        int exp_cnt;
        reset = 1;
        idle_inputs();
        mem_rdata = 32'd0;
        mem_arr[16] = 32'h1111_1111;
        mem_arr[17] = 32'h2222_2222;

        // Reset with both ports requesting: everything stays quiet.
        next_cycle();
        cpu_req = 1; dbg_req = 1; cpu_addr = 32'h40; dbg_addr = 32'h44;
        #1;
        chk("rst_cpu_gnt", 32'(cpu_gnt), 0);
        chk("rst_dbg_gnt", 32'(dbg_gnt), 0);
        chk("rst_stall", 32'(cpu_stall), 0);
        chk("rst_mem_en", 32'(mem_en), 0);
        chk("rst_mem_addr", 32'(mem_addr), 0);
        chk("rst_cnt", 32'(conflict_cnt), 0);
        next_cycle();
        chk("rst_cnt2", 32'(conflict_cnt), 0);

        // Contended reads from reset: CPU, DBG, CPU, DBG.
        next_cycle(); reset = 0; #1;
        chk("c1_cpu_gnt", 32'(cpu_gnt), 1);
        chk("c1_dbg_gnt", 32'(dbg_gnt), 0);
        chk("c1_stall", 32'(cpu_stall), 0);
        chk("c1_mem_addr", 32'(mem_addr), 16);
        chk("c1_rvalid", 32'(cpu_rvalid), 0);
        next_cycle(); #1;
        chk("c2_dbg_gnt", 32'(dbg_gnt), 1);
        chk("c2_cpu_gnt", 32'(cpu_gnt), 0);
        chk("c2_stall", 32'(cpu_stall), 1);
        chk("c2_mem_addr", 32'(mem_addr), 17);
        chk("c2_cpu_rvalid", 32'(cpu_rvalid), 1);
        chk("c2_cpu_rdata", cpu_rdata, 32'h1111_1111);
        chk("c2_dbg_rdata", dbg_rdata, 0);
        next_cycle(); #1;
        chk("c3_cpu_gnt", 32'(cpu_gnt), 1);
        chk("c3_stall", 32'(cpu_stall), 0);
        chk("c3_dbg_rvalid", 32'(dbg_rvalid), 1);
        chk("c3_dbg_rdata", dbg_rdata, 32'h2222_2222);
        chk("c3_cpu_rvalid", 32'(cpu_rvalid), 0);
        next_cycle(); #1;
        chk("c4_dbg_gnt", 32'(dbg_gnt), 1);
        chk("c4_stall", 32'(cpu_stall), 1);
        chk("c4_cpu_rdata", cpu_rdata, 32'h1111_1111);
        next_cycle(); idle_inputs(); #1;
        chk("c5_cnt", 32'(conflict_cnt), 4);
        chk("c5_dbg_rvalid", 32'(dbg_rvalid), 1);
        chk("c5_mem_en", 32'(mem_en), 0);
        next_cycle(); #1;
        chk("c6_cpu_rvalid", 32'(cpu_rvalid), 0);
        chk("c6_dbg_rvalid", 32'(dbg_rvalid), 0);

        // CPU store then load back.
        next_cycle();
        cpu_req = 1; cpu_we = 1; cpu_addr = 32'h40; cpu_wdata = 32'hDEAD_BEEF; cpu_be = 4'hF;
        #1;
        chk("st_gnt", 32'(cpu_gnt), 1);
        chk("st_mem_en", 32'(mem_en), 1);
        chk("st_mem_we", 32'(mem_we), 1);
        chk("st_mem_addr", 32'(mem_addr), 16);
        chk("st_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
        chk("st_mem_be", 32'(mem_be), 32'hF);
        next_cycle(); cpu_we = 0; cpu_wdata = 0; cpu_be = 0; #1;
        chk("st_rvalid", 32'(cpu_rvalid), 1);
        chk("st_rdata", cpu_rdata, 0);
        chk("ld_mem_we", 32'(mem_we), 0);
        chk("ld_mem_wdata", mem_wdata, 0);
        next_cycle(); idle_inputs(); #1;
        chk("ld_rvalid", 32'(cpu_rvalid), 1);
        chk("ld_rdata", cpu_rdata, 32'hDEAD_BEEF);
        chk("ld_err", 32'(cpu_err), 0);

        // Illegal accesses: misaligned debug store, out-of-range CPU load.
        next_cycle();
        dbg_req = 1; dbg_we = 1; dbg_addr = 32'h42; dbg_wdata = 32'h1234_5678; dbg_be = 4'hF;
        #1;
        chk("ill_dbg_gnt", 32'(dbg_gnt), 1);
        chk("ill_dbg_mem_en", 32'(mem_en), 0);
        chk("ill_dbg_mem_we", 32'(mem_we), 0);
        chk("ill_dbg_mem_wdata", mem_wdata, 0);
        next_cycle(); idle_inputs(); cpu_req = 1; cpu_addr = 32'h2000; #1;
        chk("ill_cpu_gnt", 32'(cpu_gnt), 1);
        chk("ill_cpu_mem_en", 32'(mem_en), 0);
        chk("ill_dbg_rvalid", 32'(dbg_rvalid), 1);
        chk("ill_dbg_err", 32'(dbg_err), 1);
        chk("ill_dbg_rdata", dbg_rdata, 0);
        next_cycle(); idle_inputs(); #1;
        chk("ill_cpu_rvalid", 32'(cpu_rvalid), 1);
        chk("ill_cpu_err", 32'(cpu_err), 1);
        chk("ill_cpu_rdata", cpu_rdata, 0);
        chk("ill_dbg_err_off", 32'(dbg_err), 0);
        next_cycle(); #1;
        chk("ill_cpu_err_off", 32'(cpu_err), 0);

        // Reset while a CPU read response is pending.
        next_cycle(); cpu_req = 1; cpu_addr = 32'h40; #1;
        chk("rp_gnt", 32'(cpu_gnt), 1);
        next_cycle(); reset = 1; dbg_req = 1; #1;
        chk("rp_rvalid_in_rst", 32'(cpu_rvalid), 0);
        chk("rp_rdata_in_rst", cpu_rdata, 0);
        chk("rp_cnt_in_rst", 32'(conflict_cnt), 0);
        chk("rp_gnt_in_rst", 32'(cpu_gnt), 0);
        next_cycle(); reset = 0; idle_inputs(); #1;
        chk("rp_rvalid_after", 32'(cpu_rvalid), 0);
        chk("rp_cnt_after", 32'(conflict_cnt), 0);

        // Long contention: strict alternation starting with CPU, counter saturates.
        for (int i = 0; i < 20; i++) begin
            next_cycle();
            cpu_req = 1; dbg_req = 1; cpu_addr = 32'h40; dbg_addr = 32'h44;
            #1;
            exp_cnt = (i > 15) ? 15 : i;
            chk($sformatf("sat_cpu_gnt_%0d", i), 32'(cpu_gnt), (i % 2 == 0) ? 1 : 0);
            chk($sformatf("sat_dbg_gnt_%0d", i), 32'(dbg_gnt), (i % 2 == 0) ? 0 : 1);
            chk($sformatf("sat_cnt_%0d", i), 32'(conflict_cnt), 32'(exp_cnt));
        end
        next_cycle(); idle_inputs(); #1;
        chk("sat_cnt_final", 32'(conflict_cnt), 32'hF);
        next_cycle(); #1;
        chk("sat_cnt_hold", 32'(conflict_cnt), 32'hF);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter ADDR_WIDTH, default 11: word-address width of the shared data memory.
REQ-002 Parameter CNT_WIDTH, default 16: width of the contention counter.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 cpu_req, cpu_we  input  1 each  CPU load/store request; write when cpu_we=1.
REQ-006 cpu_addr, cpu_wdata  input  32 each  CPU byte address; CPU store data.
REQ-007 cpu_be  input  4  CPU byte enables for stores.
REQ-008 cpu_gnt, cpu_stall, cpu_rvalid, cpu_err  output  1 each  CPU grant; stall (cpu_req & ~cpu_gnt); response valid; error.
REQ-009 cpu_rdata  output  32  CPU read data.
REQ-010 dbg_req, dbg_we, dbg_addr, dbg_wdata, dbg_be, dbg_gnt, dbg_rvalid, dbg_err, dbg_rdata: same widths/meanings for the debug/loader port; no stall output.
REQ-011 mem_en, mem_we  output  1 each  memory access strobe; write.
REQ-012 mem_addr  output  ADDR_WIDTH  word address = granted addr[ADDR_WIDTH+1:2].
REQ-013 mem_wdata  output  32; mem_be  output  4  granted store data and byte enables.
REQ-014 mem_rdata  input  32  synchronous-read data, valid one cycle after mem_en & ~mem_we.
REQ-015 conflict_cnt  output  CNT_WIDTH  number of cycles in which both ports requested.

Function
REQ-016 Grant SHALL be combinational in the request cycle; at most one of cpu_gnt/dbg_gnt SHALL be high in any cycle.
REQ-017 Single requester SHALL be granted immediately; no idle cycles between back-to-back grants (throughput 1 access/cycle).
REQ-018 Both requesting: grant the port opposite to last_grant; last_grant register SHALL update to the granted port on every grant.
REQ-019 A port not granted SHALL hold its request stable; the arbiter SHALL grant it no later than the following cycle (max wait 1 cycle).
REQ-020 Legal access = addr[1:0]==0 and addr[31:ADDR_WIDTH+2]==0; legal grant SHALL drive mem_en=1 and copy we/wdata/be/addr from winner in the same cycle.
REQ-021 Illegal access SHALL still be granted but SHALL drive mem_en=0 (no memory side effect).
REQ-022 Every grant in cycle N SHALL produce exactly one response on the granted port in cycle N+1: rvalid=1 for one cycle.
REQ-023 Response rdata SHALL equal mem_rdata for a legal read, 32'h0 for writes and errors; rdata SHALL be 0 when rvalid=0.
REQ-024 err SHALL pulse with rvalid for illegal accesses only.
REQ-025 Response routing SHALL use a registered response-port/kind record; a new grant in cycle N+1 SHALL NOT disturb the cycle N+1 response.
REQ-026 Pipeline states: IDLE (no response pending) and RESP (response due this cycle); RESP->RESP on back-to-back grants, RESP->IDLE when no grant, IDLE->RESP on any grant.
REQ-027 conflict_cnt SHALL increment by 1 each cycle with cpu_req & dbg_req, saturating at all-ones (no wrap).
REQ-028 mem_we, mem_addr, mem_wdata, mem_be SHALL be 0 whenever mem_en=0.

Reset
REQ-029 While reset=1: all grants, rvalid, err, rdata, mem_* outputs SHALL be 0, requests SHALL be ignored, conflict_cnt SHALL be 0.
REQ-030 Reset SHALL set last_grant=DBG so the CPU wins the first contended cycle.
REQ-031 Reset asserted while a response is pending SHALL discard it; no rvalid in the cycle after reset deasserts.

Verification
REQ-032 CPU store addr=0x40, wdata=0xDEADBEEF, be=4'hF, dbg idle -> cpu_gnt same cycle, mem_en=1, mem_we=1, mem_addr=16; cpu_rvalid=1, cpu_rdata=0 next cycle.
REQ-033 CPU load addr=0x40 next cycle (mem_rdata=0xDEADBEEF) -> cpu_rvalid=1, cpu_rdata=0xDEADBEEF, cpu_err=0.
REQ-034 Both ports request reads for 4 cycles from reset -> grants CPU,DBG,CPU,DBG; cpu_stall high in cycles 2,4; conflict_cnt=4.
REQ-035 dbg store addr=0x42 and a CPU load addr=0x2000 (ADDR_WIDTH=11) -> both granted, mem_en=0 both cycles; err=1, rdata=0 in the responses.
REQ-036 CPU read granted, reset asserted next cycle for 1 cycle -> no cpu_rvalid during or after reset; conflict_cnt=0.
REQ-037 Force CNT_WIDTH=4, contend 20 cycles -> conflict_cnt=4'hF, holds.
